// File: rtl/alu_writeback.sv
// alu_writeback: buffers ALU results (data + destination register) in a small
// FIFO and drains them to the register-file write port over valid/ready.
// Also holds the architectural zero flag and answers a hazard/forwarding query
// so decode can pick up results that are still in flight.
module alu_writeback #(
  parameter int DATA_W = 8,
  parameter int RD_W   = 2,
  parameter int DEPTH  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  // ALU side
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_result,
  input  logic                     in_zero,
  input  logic [RD_W-1:0]          in_rd,
  input  logic                     in_wen,
  input  logic                     in_flag_en,
  // register-file write port
  output logic                     wb_valid,
  input  logic                     wb_ready,
  output logic [DATA_W-1:0]        wb_data,
  output logic [RD_W-1:0]          wb_rd,
  // status
  output logic                     zero_flag,
  output logic [$clog2(DEPTH):0]   count,
  // hazard / forwarding query
  input  logic [RD_W-1:0]          q_rd,
  output logic                     q_hit,
  output logic [DATA_W-1:0]        q_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [RD_W-1:0]   rd;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;

  logic accept;
  logic push;
  logic pop;

  // Handshake decode. in_ready looks only at the registered count, so there
  // is no combinational path from wb_ready back to the ALU.
  assign in_ready = (count != CNT_W'(DEPTH));
  assign wb_valid = (count != '0);
  assign accept   = in_valid & in_ready;
  assign push     = accept & in_wen;
  assign pop      = wb_valid & wb_ready;

  // Head entry is presented directly; outputs are forced to 0 when empty.
  assign wb_data = wb_valid ? mem[head].data : '0;
  assign wb_rd   = wb_valid ? mem[head].rd   : '0;

  // Pointers, occupancy and zero flag; pointers wrap naturally at DEPTH.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking (=) here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      zero_flag <= 1'b0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (accept && in_flag_en) zero_flag <= in_zero;
    end
  end

  // Entry storage, written at the tail on every enqueue.
  // NOTE: the storage array has no reset on purpose; validity is carried by
  // count/head, and every read path is gated by it, so stale contents are
  // never observable and the array can map onto plain flops or LUT-RAM.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= '{data: in_result, rd: in_rd};
  end

  // Forwarding search: walk valid entries oldest to youngest so the last
  // match (closest to tail) wins. The entry being accepted this cycle is not
  // in mem yet, so it is naturally excluded; an entry popping this cycle is
  // still counted because count has not dropped yet.
  // NOTE: outputs get defaults before the loop so no path leaves them
  // unassigned; without the defaults this block would infer latches.
  always_comb begin
    q_hit  = 1'b0;
    q_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((CNT_W'(k) < count) && (mem[head + PTR_W'(k)].rd == q_rd)) begin
        q_hit  = 1'b1;
        q_data = mem[head + PTR_W'(k)].data;
      end
    end
  end

endmodule

// File: tb/tb_alu_writeback.sv
// Testbench for alu_writeback: directed vectors; expected writebacks are
// queued when issued and a separate monitor checks each pop in order.
module tb_alu_writeback;

  localparam int DATA_W = 8;
  localparam int RD_W   = 2;
  localparam int DEPTH  = 2;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_result;
  logic              in_zero;
  logic [RD_W-1:0]   in_rd;
  logic              in_wen;
  logic              in_flag_en;
  logic              wb_valid;
  logic              wb_ready;
  logic [DATA_W-1:0] wb_data;
  logic [RD_W-1:0]   wb_rd;
  logic              zero_flag;
  logic [$clog2(DEPTH):0] count;
  logic [RD_W-1:0]   q_rd;
  logic              q_hit;
  logic [DATA_W-1:0] q_data;

  int total = 0;
  int bad   = 0;

  // expected writebacks, {rd, data}
  logic [RD_W+DATA_W-1:0] exp_q [$];

  alu_writeback #(.DATA_W(DATA_W), .RD_W(RD_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_zero(in_zero), .in_rd(in_rd), .in_wen(in_wen), .in_flag_en(in_flag_en),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_rd(wb_rd),
    .zero_flag(zero_flag), .count(count),
    .q_rd(q_rd), .q_hit(q_hit), .q_data(q_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // present one ALU op; writes are expected to come out of the FIFO in order
  task automatic issue(input logic [DATA_W-1:0] r, input logic z, input logic [RD_W-1:0] rd,
                       input logic wen, input logic fe);
    in_valid   = 1'b1;
    in_result  = r;
    in_zero    = z;
    in_rd      = rd;
    in_wen     = wen;
    in_flag_en = fe;
    if (wen) exp_q.push_back({rd, r});
  endtask

  task automatic idle();
    in_valid   = 1'b0;
    in_wen     = 1'b0;
    in_flag_en = 1'b0;
  endtask

  // Monitor: every pop (wb_valid & wb_ready before the edge) must match the
  // oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && wb_valid && wb_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pop: got %0h/rd%0d expected none", wb_data, wb_rd);
      end else begin
        logic [RD_W+DATA_W-1:0] e;
        e = exp_q.pop_front();
        check("wb_pop", {wb_rd, wb_data}, e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; wb_ready = 1'b0; q_rd = '0;
    in_result = '0; in_zero = 1'b0; in_rd = '0;
    idle();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    // reset / idle
    check("rst_count", count, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_wb_rd", wb_rd, 0);
    check("rst_zero_flag", zero_flag, 0);
    check("rst_in_ready", in_ready, 1);

    // single write, drained immediately
    wb_ready = 1'b1;
    issue(8'b00101001, 1'b0, 2'd1, 1'b1, 1'b1);
    step(); idle();
    check("sw_wb_valid", wb_valid, 1);
    check("sw_wb_data", wb_data, 8'h29);
    check("sw_wb_rd", wb_rd, 1);
    check("sw_zero_flag", zero_flag, 0);
    step();
    check("sw_drained", wb_valid, 0);

    // backpressure until full
    wb_ready = 1'b0;
    issue(8'h11, 1'b0, 2'd0, 1'b1, 1'b0);
    step();
    issue(8'h22, 1'b0, 2'd2, 1'b1, 1'b0);
    step(); idle();
    check("full_count", count, 2);
    check("full_in_ready", in_ready, 0);
    check("full_head", {wb_rd, wb_data}, {2'd0, 8'h11});
    // rejected op (also carrying a flag update) while popping: nothing taken
    in_valid = 1'b1; in_result = 8'h33; in_rd = 2'd1; in_wen = 1'b1;
    in_flag_en = 1'b1; in_zero = 1'b1;
    wb_ready = 1'b1;
    step(); idle();
    check("rej_count", count, 1);
    check("rej_zero_flag", zero_flag, 0);
    check("rej_in_ready_after_pop", in_ready, 1);
    step();
    check("full_drained", count, 0);

    // flag-only ops
    issue(8'h00, 1'b1, 2'd0, 1'b0, 1'b1);
    step();
    check("fo_count", count, 0);
    check("fo_wb_valid", wb_valid, 0);
    check("fo_zero_flag", zero_flag, 1);
    issue(8'h44, 1'b0, 2'd2, 1'b0, 1'b0);
    step();
    check("fo_hold_flag", zero_flag, 1);
    issue(8'h66, 1'b0, 2'd1, 1'b1, 1'b1);
    step(); idle();
    check("fo_clear_flag", zero_flag, 0);
    step();
    check("fo_drained", count, 0);

    // hazard query
    wb_ready = 1'b0;
    q_rd = 2'd3;
    issue(8'hA0, 1'b0, 2'd3, 1'b1, 1'b0);
    #1 check("hz_accepting_invisible", q_hit, 0);
    step();
    issue(8'hB0, 1'b0, 2'd3, 1'b1, 1'b0);
    #1 check("hz_older_only", q_data, 8'hA0);
    step(); idle();
    check("hz_hit", q_hit, 1);
    check("hz_youngest", q_data, 8'hB0);
    q_rd = 2'd1;
    #1;
    check("hz_miss_hit", q_hit, 0);
    check("hz_miss_data", q_data, 0);
    q_rd = 2'd3;
    wb_ready = 1'b1;
    step();
    check("hz_popping_counts", {q_hit, q_data}, {1'b1, 8'hB0});
    step();
    check("hz_empty", {q_hit, q_data}, 9'h0);

    // simultaneous push/pop at count=1 across pointer wraps
    wb_ready = 1'b0;
    issue(8'h50, 1'b0, 2'd1, 1'b1, 1'b0);
    step();
    wb_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [7:0] d;
      d = 8'h55 + 8'(i);
      issue(d, 1'b0, 2'(i), 1'b1, 1'b0);
      step();
      check("pp_count", count, 1);
      check("pp_head", wb_data, d);
    end
    // fill to 2 then reset mid-drain between edges
    wb_ready = 1'b0;
    issue(8'h77, 1'b0, 2'd2, 1'b1, 1'b0);
    step(); idle();
    check("pre_rst_count", count, 2);
    #2 rst_n = 1'b0;
    #1;
    check("arst_wb_valid", wb_valid, 0);
    check("arst_count", count, 0);
    check("arst_wb_data", wb_data, 0);
    exp_q.delete();
    wb_ready = 1'b1;
    step();
    rst_n = 1'b1;
    repeat (3) step();
    check("post_rst_count", count, 0);
    check("sb_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
